// File: rtl/rr_req_queue.sv
// rr_req_queue: per-source request FIFOs in front of a 4-way round-robin arbiter.
// Each source pushes into its own FIFO; FIFO occupancy drives request_sig, and the
// arbiter's registered one-hot grant pops the granted head into one registered
// valid/ready output channel.
// Optional build macro: RR_REQ_QUEUE_GRANT_CHK_EN enables the sticky grant_err
// protocol checker (grant with multiple bits set, or grant without a prior request).
// Without the macro grant_err is tied low.
module rr_req_queue #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [N_REQ-1:0]           in_valid,
  input  logic [N_REQ*DATA_W-1:0]    in_data,
  output logic [N_REQ-1:0]           in_ready,
  output logic [N_REQ-1:0]           request_sig,
  input  logic [N_REQ-1:0]           grant,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(N_REQ)-1:0]   out_src,
  input  logic                       out_ready,
  output logic                       grant_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SRC_W = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem   [N_REQ][DEPTH];
  logic [PTR_W-1:0]  head  [N_REQ];
  logic [PTR_W-1:0]  tail  [N_REQ];
  logic [CNT_W-1:0]  count [N_REQ];

  logic [N_REQ-1:0]  not_empty;
  logic [N_REQ-1:0]  push;
  logic [N_REQ-1:0]  pop;
  logic              slot_free;
  logic              grant_onehot;
  logic              pop_any;
  logic [SRC_W-1:0]  pop_idx;
  logic [DATA_W-1:0] head_data;

  // Handshake decode: FIFO status, arbiter requests and per-source push/pop enables.
  // A request is only raised when the output register can take a word, so a stalled
  // output never lets the arbiter grant into a blocked slot.
  always_comb begin
    slot_free    = !out_valid || out_ready;
    grant_onehot = (grant != '0) && ((grant & (grant - N_REQ'(1))) == '0);
    for (int i = 0; i < N_REQ; i++) begin
      not_empty[i]   = (count[i] != '0);
      in_ready[i]    = (count[i] != FULL_CNT);
      request_sig[i] = not_empty[i] && slot_free;
      push[i]        = in_valid[i] && in_ready[i];
      pop[i]         = grant[i] && grant_onehot && not_empty[i] && slot_free;
    end
  end

  // Select the popped source and its head entry (at most one pop bit is set).
  always_comb begin
    pop_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pop[i]) pop_idx = SRC_W'(i);
    end
    pop_any   = |pop;
    head_data = mem[pop_idx][head[pop_idx]];
  end

  // FIFO storage: payload only, validity is tracked by the pointers and counts.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (push[i]) mem[i][tail[i]] <= in_data[i*DATA_W +: DATA_W];
    end
  end

  // FIFO pointers and occupancy; a push and pop on the same FIFO leave count unchanged.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_REQ; i++) begin
        head[i]  <= '0;
        tail[i]  <= '0;
        count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (push[i]) tail[i] <= tail[i] + PTR_W'(1);
        if (pop[i])  head[i] <= head[i] + PTR_W'(1);
        if (push[i] && !pop[i])      count[i] <= count[i] + CNT_W'(1);
        else if (pop[i] && !push[i]) count[i] <= count[i] - CNT_W'(1);
      end
    end
  end

  // Output register: load on pop, drain when accepted, hold while stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (pop_any) begin
      out_valid <= 1'b1;
      out_data  <= head_data;
      out_src   <= pop_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef RR_REQ_QUEUE_GRANT_CHK_EN
  logic [N_REQ-1:0] req_q;
  logic             grant_multi;
  logic             grant_unreq;

  // A grant is suspicious if it has several bits, or targets an empty FIFO that
  // was not requesting last cycle (the normal one-cycle grant lag is excluded).
  always_comb begin
    grant_multi = ((grant & (grant - N_REQ'(1))) != '0);
    grant_unreq = |(grant & ~not_empty & ~req_q);
  end

  // Remember last cycle's requests and latch the sticky error flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_q     <= '0;
      grant_err <= 1'b0;
    end else begin
      req_q <= request_sig;
      if (grant_multi || grant_unreq) grant_err <= 1'b1;
    end
  end
`else
  assign grant_err = 1'b0;
`endif

endmodule
